// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the KTC32 load/store unit.
// Access-size and FSM-state encodings plus the sub-word store merge helper.
package ktc32_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } mau_state_t;

  localparam int unsigned MEM_BYTES_DEFAULT = 32768;

  // Overlay the right-aligned store data onto the word read back from RAM.
  function automatic logic [31:0] store_merge(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input mem_size_t   size
  );
    logic [31:0] merged;
    merged = wdata;
    case (size)
      MEM_B:   merged = {old_word[31:8], wdata[7:0]};
      MEM_H:   merged = {old_word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load result formatter: byte/half zero- or sign-extension, words pass through.
module load_extend
  import ktc32_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  mem_size_t size_e;

  always_comb begin
    size_e = mem_size_t'(size);
    result = word;
    case (size_e)
      MEM_B:   result = {{24{sign_ext & word[7]}}, word[7:0]};
      MEM_H:   result = {{16{sign_ext & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit driving a combinational-read 32-bit RAM; sub-word stores use read-modify-write.
// Optional macro KTC32_ALIGN_CHECK_EN turns misaligned half/word requests into error responses.
module mem_access_unit
  import ktc32_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_data
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 4);

  mau_state_t        state_q, state_d;
  logic              we_q, we_d;
  mem_size_t         size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;

  mem_size_t   req_size_e;
  logic        req_err;
  logic [31:0] load_result;

  always_comb begin
    req_size_e = mem_size_t'(req_size);
    req_err    = (req_size_e == MEM_RSVD) || (req_addr > ADDR_LIMIT);
`ifdef KTC32_ALIGN_CHECK_EN
    if ((req_size_e == MEM_H) && req_addr[0])
      req_err = 1'b1;
    if ((req_size_e == MEM_W) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size_e;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err)
            state_d = RESP;
          else if (req_we && (req_size_e == MEM_W))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        word_d  = mem_data;
        state_d = we_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= MEM_B;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      err_q    <= err_d;
    end
  end

  load_extend u_load_extend (
    .word     (word_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .result   (load_result)
  );

  // All handshake and RAM strobes decode straight from the state register so
  // an asynchronous reset removes them in the same cycle, including a pending write.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_we     = (state_q == WR);
    mem_addr   = addr_q;
    mem_wd     = (state_q == WR) ? store_merge(word_q, wdata_q, size_q) : '0;
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? load_result : '0;
  end

endmodule
